// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment display controller: hex or decimal (shift-add-3) conversion,
// leading-zero blanking, overflow dashes and per-digit blink, all on a registered segment bus.
module seg7_display_ctrl #(
   parameter int NDIG       = 6,
   parameter int DW         = 20,
   parameter int ACTIVE_LOW = 1,
   parameter int BLINK_DIV  = 20000000
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              load,
   input  logic [DW-1:0]     value,
   input  logic              dec_mode,
   input  logic              blank_lz,
   input  logic [NDIG-1:0]   blink_en,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [7*NDIG-1:0] seg
);
   localparam int BW  = 4*NDIG + 4;
   localparam int CW  = $clog2(DW + 1);
   localparam int BCW = $clog2(BLINK_DIV);

   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
   state_t state_q, state_d;

   logic [BW-1:0]          bcd_q, bcd_adj;
   logic [DW-1:0]          sh_q;
   logic [CW-1:0]          cnt_q;
   logic                   lz_q, trunc_q, ovf_q, ovf_d;
   logic [NDIG-1:0][6:0]   glyph_q, new_glyph, glyph_src;
   logic [BCW-1:0]         bcnt_q;
   logic                   phase_q;
   logic [7*NDIG-1:0]      seg_q, seg_d;
   logic                   seen;
   logic [3:0]             nib;
   logic [6:0]             g;

   function automatic logic [6:0] hex7(input logic [3:0] d);
      case (d)
         4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE:    if (load) state_d = dec_mode ? CONV : COMMIT;
         CONV: begin
            busy = 1'b1;
            if (cnt_q == '0) state_d = COMMIT;
         end
         COMMIT: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Add-3 correction on every BCD digit before the shift
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < NDIG + 1; i++)
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   // Hex loads go straight into the BCD register so commit treats both modes alike;
   // trunc_q catches digits shifted off the top for values wider than the register.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         bcd_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         lz_q    <= 1'b0;
         trunc_q <= 1'b0;
      end else if (state_q == IDLE && load) begin
         lz_q    <= blank_lz;
         trunc_q <= 1'b0;
         cnt_q   <= CW'(DW - 1);
         if (dec_mode) begin
            sh_q  <= value;
            bcd_q <= '0;
         end else begin
            sh_q  <= '0;
            bcd_q <= BW'(value);
         end
      end else if (state_q == CONV) begin
         bcd_q   <= {bcd_adj[BW-2:0], sh_q[DW-1]};
         sh_q    <= sh_q << 1;
         trunc_q <= trunc_q | bcd_adj[BW-1];
         cnt_q   <= cnt_q - 1'b1;
      end
   end

   always_comb begin
      ovf_d     = trunc_q | (|bcd_q[BW-1:4*NDIG]);
      new_glyph = '0;
      seen      = 1'b0;
      nib       = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         nib = bcd_q[4*k +: 4];
         if (nib != 4'd0) seen = 1'b1;
         if (ovf_d)                          new_glyph[k] = 7'h40;
         else if (lz_q && !seen && k != 0)   new_glyph[k] = 7'h00;
         else                                new_glyph[k] = hex7(nib);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         glyph_q <= '0;
         ovf_q   <= 1'b0;
      end else if (state_q == COMMIT) begin
         glyph_q <= new_glyph;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
      end else if (bcnt_q == BCW'(BLINK_DIV - 1)) begin
         bcnt_q  <= '0;
         phase_q <= ~phase_q;
      end else begin
         bcnt_q  <= bcnt_q + BCW'(1);
      end
   end

   // Commit-cycle glyphs are forwarded so seg updates on the same edge as the commit
   always_comb begin
      glyph_src = (state_q == COMMIT) ? new_glyph : glyph_q;
      seg_d     = '0;
      g         = '0;
      for (int k = 0; k < NDIG; k++) begin
         g = (phase_q && blink_en[k]) ? 7'h00 : glyph_src[k];
         seg_d[7*k +: 7] = (ACTIVE_LOW != 0) ? ~g : g;
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) seg_q <= (ACTIVE_LOW != 0) ? '1 : '0;
      else       seg_q <= seg_d;
   end

   assign seg = seg_q;
   assign ovf = ovf_q;
endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed checks of seg7_display_ctrl: reset, hex/decimal commit, overflow,
// ignored loads, blinking and reset during conversion.
module tb_seg7_display_ctrl;
   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        load = 1'b0;
   logic [19:0] value = '0;
   logic        dec_mode = 1'b0;
   logic        blank_lz = 1'b0;
   logic [5:0]  blink_en = '0;
   logic        busy, done, ovf;
   logic [41:0] seg;

   int passes = 0;
   int total  = 0;

   seg7_display_ctrl #(.NDIG(6), .DW(20), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut (
      .clk(clk), .nrst(nrst), .load(load), .value(value), .dec_mode(dec_mode),
      .blank_lz(blank_lz), .blink_en(blink_en), .busy(busy), .done(done),
      .ovf(ovf), .seg(seg)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the bench at the first negedge after the capturing edge
   task automatic do_load(input logic [19:0] v, input logic dm, input logic lz);
      value = v; dec_mode = dm; blank_lz = lz; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   // Returns the negedge index (1 = first after load edge) at which done is seen, 0 on timeout
   task automatic wait_done(output int at);
      at = 0;
      for (int i = 1; i <= 40; i++) begin
         if (done) begin
            at = i;
            break;
         end
         step();
      end
   endtask

   initial begin
      int at, busy_cnt, j, errs, up_errs, done_seen;
      logic [6:0] d [16];
      logic [34:0] up;

      // reset
      step(); step();
      chk("rst_seg", seg, 42'h3FF_FFFF_FFFF);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovf", ovf, 0);
      nrst = 1'b1;
      step();

      // hex with leading-zero blanking
      do_load(20'h0A3F0, 1'b0, 1'b1);
      chk("hex_done", done, 1);
      chk("hex_busy", busy, 0);
      step();
      chk("hex_seg", seg, {7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h40});
      chk("hex_done_pulse", done, 0);
      chk("hex_ovf", ovf, 0);

      // decimal 123456 with an ignored load during CONV
      value = 20'd123456; dec_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
      busy_cnt = 0; at = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 1) load = 1'b0;
         if (i == 5) begin load = 1'b1; value = 20'd5; dec_mode = 1'b0; end
         if (i == 6) load = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin at = i; break; end
      end
      chk("dec_busy_cycles", busy_cnt, 20);
      chk("dec_done_at", at, 21);
      step();
      chk("dec_seg", seg, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
      chk("dec_ovf", ovf, 0);

      // overflow, then cleared by a hex zero
      do_load(20'd1000000, 1'b1, 1'b0);
      wait_done(at);
      chk("ovf_done_at", at, 21);
      step();
      chk("ovf_flag", ovf, 1);
      chk("ovf_seg", seg, {6{7'h3F}});
      do_load(20'h00000, 1'b0, 1'b1);
      wait_done(at);
      chk("zero_done_at", at, 1);
      step();
      chk("zero_ovf", ovf, 0);
      chk("zero_seg", seg, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40});

      // blink digit 0
      do_load(20'h12345, 1'b0, 1'b0);
      wait_done(at);
      step();
      chk("blk_base_seg", seg, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
      blink_en = 6'b000001;
      up_errs = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         d[i] = seg[6:0];
         up = seg[41:7];
         if (up !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h19}) up_errs++;
      end
      j = 0;
      for (int i = 1; i <= 4; i++)
         if (j == 0 && d[i] !== d[i-1]) j = i;
      chk("blk_edge_found", (j != 0), 1);
      if (j == 0) j = 1;
      chk("blk_pair", ((d[j] === 7'h12 && d[j-1] === 7'h7F) ||
                       (d[j] === 7'h7F && d[j-1] === 7'h12)), 1);
      errs = 0;
      for (int i = j; i < 16; i++)
         if (d[i] !== ((((i - j) / 4) % 2 == 0) ? d[j] : d[j-1])) errs++;
      chk("blk_period", errs, 0);
      chk("blk_others_steady", up_errs, 0);
      blink_en = '0;
      step();

      // reset at CONV cycle 10
      do_load(20'd123456, 1'b1, 1'b0);
      for (int i = 2; i <= 10; i++) step();
      nrst = 1'b0;
      step();
      chk("rconv_busy", busy, 0);
      chk("rconv_done", done, 0);
      chk("rconv_seg", seg, 42'h3FF_FFFF_FFFF);
      chk("rconv_ovf", ovf, 0);
      nrst = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (done) done_seen++;
      end
      chk("rconv_no_done", done_seen, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
